// File: rtl/key_conditioner_pkg.sv
// Shared defaults and sizing helper for the push-button conditioning front end.
// Optional auto-repeat is controlled by the KEY_AUTOREPEAT_EN macro in the consumers.
package key_cond_pkg;

    localparam int KEY_DEBOUNCE_DEFAULT = 8;
    localparam int KEY_REPEAT_DEFAULT   = 16;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_conditioner_if.sv
// Key bus between the raw board buttons and the conditioned outputs.
// master drives raw keys and observes results; slave is the conditioner.
interface key_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_raw;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic                any_press;

    modport master (
        output key_raw,
        input  key_level,
        input  key_press,
        input  any_press
    );

    modport slave (
        input  key_raw,
        output key_level,
        output key_press,
        output any_press
    );
endinterface

// File: rtl/key_debounce.sv
// One key: 2-flop synchroniser, debounce counter, press edge detect.
// With KEY_AUTOREPEAT_EN defined, a held key also pulses every REPEAT_PERIOD cycles.
module key_debounce
    import key_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int REPEAT_PERIOD   = KEY_REPEAT_DEFAULT
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic key_level,
    output logic key_press
);
    localparam int             CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             pressed;
    logic             s1_reg;
    logic             s2_reg;
    logic             stable_reg;
    logic             stable_next;
    logic             stable_d_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             first_press;

    assign pressed = key_raw ^ ACTIVE_LOW;

    // Any sample agreeing with the accepted state restarts the count.
    always_comb begin
        cnt_next    = '0;
        stable_next = stable_reg;
        if (s2_reg != stable_reg) begin
            if (cnt_reg == CNT_LAST) begin
                stable_next = s2_reg;
            end else begin
                cnt_next = cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_reg       <= 1'b0;
            s2_reg       <= 1'b0;
            stable_reg   <= 1'b0;
            stable_d_reg <= 1'b0;
            cnt_reg      <= '0;
        end else begin
            s1_reg       <= pressed;
            s2_reg       <= s1_reg;
            stable_reg   <= stable_next;
            stable_d_reg <= stable_reg;
            cnt_reg      <= cnt_next;
        end
    end

    assign first_press = stable_reg & ~stable_d_reg;
    assign key_level   = stable_reg;

`ifdef KEY_AUTOREPEAT_EN
    localparam int             RPT_W    = cnt_width(REPEAT_PERIOD);
    localparam logic [RPT_W-1:0] RPT_LAST = RPT_W'(REPEAT_PERIOD - 1);

    logic [RPT_W-1:0] rpt_reg;
    logic             repeat_hit;

    assign repeat_hit = stable_reg & (rpt_reg == RPT_LAST);

    always_ff @(posedge clk) begin
        if (reset || !stable_reg || first_press || repeat_hit) begin
            rpt_reg <= '0;
        end else begin
            rpt_reg <= rpt_reg + 1'b1;
        end
    end

    assign key_press = first_press | repeat_hit;
`else
    assign key_press = first_press;
`endif

endmodule

// File: rtl/key_conditioner.sv
// Conditions NUM_KEYS raw push-buttons into debounced levels and press pulses.
// Optional auto-repeat is built only when KEY_AUTOREPEAT_EN is defined.
module key_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = KEY_DEBOUNCE_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int REPEAT_PERIOD   = KEY_REPEAT_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    key_conditioner_if.slave bus
);
    logic [NUM_KEYS-1:0] level_vec;
    logic [NUM_KEYS-1:0] press_vec;

    if (DEBOUNCE_CYCLES < 2 || REPEAT_PERIOD < 2) begin : g_param_check
        $error("key_conditioner: DEBOUNCE_CYCLES and REPEAT_PERIOD must be >= 2");
    end

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_key (
            .clk       (clk),
            .reset     (reset),
            .key_raw   (bus.key_raw[gi]),
            .key_level (level_vec[gi]),
            .key_press (press_vec[gi])
        );
    end

    assign bus.key_level = level_vec;
    assign bus.key_press = press_vec;
    assign bus.any_press = |press_vec;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_PERIOD=4, active-low keys.
// Expected levels are hand-written per cycle; expected pulses follow from the level history.
module tb_key_conditioner;
    localparam int NK = 4;
    localparam int D  = 4;
    localparam int R  = 4;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk   = 1'b0;
    logic reset = 1'b1;

    key_conditioner_if #(.NUM_KEYS(NK)) bus ();

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .ACTIVE_LOW      (1'b1),
        .REPEAT_PERIOD   (R)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int held [NK];

    task automatic check(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one edge, then compare level, press and any_press against expectations.
    // A press pulse is expected on the first cycle of a level, and every R cycles when auto-repeat is built.
    task automatic tick(input string tag, input logic [NK-1:0] exp_level);
        logic [NK-1:0] exp_press;
        @(posedge clk);
        #1;
        exp_press = '0;
        for (int i = 0; i < NK; i++) begin
            if (exp_level[i]) begin
                held[i] = (held[i] < 0) ? 0 : held[i] + 1;
            end else begin
                held[i] = -1;
            end
            exp_press[i] = exp_level[i] && ((held[i] == 0) || (AR && (held[i] % R == 0)));
        end
        check({tag, " level"}, bus.key_level, exp_level);
        check({tag, " press"}, bus.key_press, exp_press);
        check({tag, " any"}, NK'(bus.any_press), NK'(|exp_press));
        $display("[%0t] %s raw=%b level=%b press=%b any=%b", $time, tag,
                 bus.key_raw, bus.key_level, bus.key_press, bus.any_press);
    endtask

    task automatic ticks(input string tag, input int n, input logic [NK-1:0] exp_level);
        for (int k = 0; k < n; k++) begin
            tick(tag, exp_level);
        end
    endtask

    initial begin
        for (int i = 0; i < NK; i++) held[i] = -1;
        bus.key_raw = 4'b1111;
        reset       = 1'b1;

        // 1: reset with all keys released
        ticks("rst", 2, 4'b0000);
        reset = 1'b0;
        ticks("idle", 2, 4'b0000);

        // 2: key0 pressed and held; level rises on the 6th edge
        bus.key_raw = 4'b1110;
        ticks("k0_press_wait", 5, 4'b0000);
        ticks("k0_press_held", 7, 4'b0001);

        // 3: 3-cycle glitch on key1 is rejected
        bus.key_raw = 4'b1100;
        ticks("k1_glitch", 3, 4'b0001);
        bus.key_raw = 4'b1110;
        ticks("k1_glitch_after", 10, 4'b0001);

        // 4: release key0, then bounce and hold
        bus.key_raw = 4'b1111;
        ticks("k0_release_wait", 5, 4'b0001);
        ticks("k0_released", 3, 4'b0000);
        bus.key_raw = 4'b1110;
        tick("bounce0", 4'b0000);
        bus.key_raw = 4'b1111;
        tick("bounce1", 4'b0000);
        bus.key_raw = 4'b1110;
        tick("bounce2", 4'b0000);
        bus.key_raw = 4'b1111;
        tick("bounce3", 4'b0000);
        bus.key_raw = 4'b1110;
        ticks("bounce_hold_wait", 5, 4'b0000);
        ticks("bounce_hold", 3, 4'b0001);

        // 5: key0 and key2 pressed on the same edge
        bus.key_raw = 4'b1111;
        ticks("k0_release2_wait", 5, 4'b0001);
        ticks("k0_released2", 3, 4'b0000);
        bus.key_raw = 4'b1010;
        ticks("k02_wait", 5, 4'b0000);
        ticks("k02_held", 3, 4'b0101);

        // 6: key0 held across a mid-count reset
        bus.key_raw = 4'b1111;
        ticks("k02_release_wait", 5, 4'b0101);
        ticks("k02_released", 3, 4'b0000);
        bus.key_raw = 4'b1110;
        ticks("k0_midcount", 3, 4'b0000);
        reset = 1'b1;
        ticks("k0_in_reset", 2, 4'b0000);
        reset = 1'b0;
        ticks("k0_post_rst_wait", 5, 4'b0000);
        ticks("k0_post_rst_held", 9, 4'b0001);
        bus.key_raw = 4'b1111;
        ticks("k0_final_release_wait", 5, 4'b0001);
        ticks("k0_final_released", 2, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
